// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns RV32I instruction requests (class + fields) into
// 32-bit machine words and streams them into instruction memory at consecutive
// word addresses, one word per request, until DEPTH words have been written.
// Optional feature macro: ENC_RANGE_CHECK_EN -- immediates that do not fit their
// field are replaced by a NOP word and raise a sticky err flag.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_f7b5,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } loaderState;

    localparam logic [31:0]     NOP_WORD    = 32'h0000_0013;
    localparam logic [ADDR_W:0] DEPTH_COUNT = (ADDR_W + 1)'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Bit layout of each instruction format; immediates are simply truncated.
    function automatic logic [31:0] encodeWord(
        input logic [3:0]  cls,
        input logic [2:0]  f3,
        input logic        f7b5,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (cls)
            4'd0: word = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_R};
            4'd1: begin
                // Shifts carry funct7 in the top bits and a 5-bit shamt.
                if (f3 == 3'b001 || f3 == 3'b101)
                    word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, OP_IALU};
                else
                    word = {imm[11:0], rs1, f3, rd, OP_IALU};
            end
            4'd2: word = {imm[11:0], rs1, f3, rd, OP_LOAD};
            4'd3: word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            4'd4: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            4'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            4'd6: word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            4'd7: word = {imm[31:12], rd, OP_LUI};
            4'd8: word = {imm[31:12], rd, OP_AUIPC};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

`ifdef ENC_RANGE_CHECK_EN
    // True when the immediate cannot be represented exactly by its format.
    function automatic logic rangeError(input logic [3:0] cls, input logic [31:0] imm);
        logic fits12;
        logic fits13;
        logic fits21;
        logic bad;
        fits12 = (imm[31:11] == {21{imm[11]}});
        fits13 = (imm[31:12] == {20{imm[12]}});
        fits21 = (imm[31:20] == {12{imm[20]}});
        case (cls)
            4'd1, 4'd2, 4'd3, 4'd6: bad = !fits12;
            4'd4:                   bad = !fits13 || imm[0];
            4'd5:                   bad = !fits21 || imm[0];
            4'd7, 4'd8:             bad = (imm[11:0] != 12'h000);
            default:                bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    loaderState        stateReg, stateNext;
    logic [ADDR_W-1:0] ptrReg, ptrNext;
    logic [ADDR_W:0]   countReg, countNext, countInc;
    logic [31:0]       dataReg, dataNext;
    logic [31:0]       encodedWord, acceptWord;
    logic              encodeBad;
    logic              readyInt;
    logic              wrEnInt;
`ifdef ENC_RANGE_CHECK_EN
    logic              errReg, errNext;
`endif

    assign encodedWord = encodeWord(req_class, req_funct3, req_f7b5,
                                    req_rd, req_rs1, req_rs2, req_imm);
`ifdef ENC_RANGE_CHECK_EN
    assign encodeBad = rangeError(req_class, req_imm);
`else
    assign encodeBad = 1'b0;
`endif
    assign acceptWord = encodeBad ? NOP_WORD : encodedWord;

    // Next-state and handshake outputs; start overrides everything else.
    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        countNext = countReg;
        dataNext  = dataReg;
`ifdef ENC_RANGE_CHECK_EN
        errNext   = errReg;
`endif
        readyInt  = 1'b0;
        wrEnInt   = 1'b0;
        countInc  = countReg + (ADDR_W + 1)'(1);
        case (stateReg)
            IDLE: begin
                readyInt = 1'b1;
                if (req_valid) begin
                    dataNext  = acceptWord;
                    stateNext = WRITE;
`ifdef ENC_RANGE_CHECK_EN
                    errNext   = errReg | encodeBad;
`endif
                end
            end
            WRITE: begin
                wrEnInt = 1'b1;
                if (wr_ready) begin
                    countNext = countInc;
                    // The pointer stops at the last slot so the address never wraps.
                    if (countInc == DEPTH_COUNT) begin
                        stateNext = FULL;
                    end else begin
                        ptrNext   = ptrReg + ADDR_W'(1);
                        stateNext = IDLE;
                    end
                end
            end
            FULL:    stateNext = FULL;
            default: stateNext = IDLE;
        endcase
        if (start) begin
            stateNext = IDLE;
            ptrNext   = '0;
            countNext = '0;
            readyInt  = 1'b0;
            wrEnInt   = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
            errNext   = 1'b0;
`endif
        end
    end

    // State, pointer, counter and latched word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            ptrReg   <= '0;
            countReg <= '0;
            dataReg  <= '0;
`ifdef ENC_RANGE_CHECK_EN
            errReg   <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
            countReg <= countNext;
            dataReg  <= dataNext;
`ifdef ENC_RANGE_CHECK_EN
            errReg   <= errNext;
`endif
        end
    end

    // req_ready is forced low while reset is asserted.
    assign req_ready = readyInt & reset_n;
    assign wr_en     = wrEnInt;
    assign wr_addr   = ptrReg;
    assign wr_data   = dataReg;
    assign count     = countReg;
    assign full      = (stateReg == FULL);
`ifdef ENC_RANGE_CHECK_EN
    assign err       = errReg;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader (DEPTH=4 so the full condition is reachable).
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_class = '0;
    logic [2:0]        req_funct3 = '0;
    logic              req_f7b5 = 1'b0;
    logic [4:0]        req_rd = '0;
    logic [4:0]        req_rs1 = '0;
    logic [4:0]        req_rs2 = '0;
    logic [31:0]       req_imm = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int checks = 0;
    int failures = 0;
    int modelCount = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct3(req_funct3), .req_f7b5(req_f7b5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder: fields placed by weight, immediate bits picked by division/modulo.
    function automatic int unsigned refEncode(input int unsigned cls, input int unsigned f3,
                                              input int unsigned f7b5, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned imm);
        int unsigned w;
        case (cls)
            0: w = 'h33 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7b5 << 30;
            1: begin
                if (f3 == 1 || f3 == 5)
                    w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (imm % 32) << 20 | f7b5 << 30;
                else
                    w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (imm % 4096) << 20;
            end
            2: w = 'h03 | rd << 7 | f3 << 12 | rs1 << 15 | (imm % 4096) << 20;
            3: w = 'h23 | (imm % 32) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm / 32) % 128) << 25;
            4: w = 'h63 | ((imm / 2048) % 2) << 7 | ((imm / 2) % 16) << 8 | f3 << 12 | rs1 << 15
                   | rs2 << 20 | ((imm / 32) % 64) << 25 | ((imm / 4096) % 2) << 31;
            5: w = 'h6F | rd << 7 | ((imm / 4096) % 256) << 12 | ((imm / 2048) % 2) << 20
                   | ((imm / 2) % 1024) << 21 | ((imm / 1048576) % 2) << 31;
            6: w = 'h67 | rd << 7 | rs1 << 15 | (imm % 4096) << 20;
            7: w = 'h37 | rd << 7 | (imm - imm % 4096);
            8: w = 'h17 | rd << 7 | (imm - imm % 4096);
            default: w = 'h13;
        endcase
        return w;
    endfunction

    // Word the memory should receive, including range-check substitution when enabled.
    function automatic int unsigned refExpected(input int unsigned cls, input int unsigned f3,
                                                input int unsigned f7b5, input int unsigned rd,
                                                input int unsigned rs1, input int unsigned rs2,
                                                input int unsigned imm);
`ifdef ENC_RANGE_CHECK_EN
        int s;
        bit bad;
        s = int'(imm);
        case (cls)
            1, 2, 3, 6: bad = (s < -2048 || s > 2047);
            4:          bad = (s < -4096 || s > 4095 || (imm % 2) != 0);
            5:          bad = (s < -1048576 || s > 1048575 || (imm % 2) != 0);
            7, 8:       bad = (imm % 4096) != 0;
            default:    bad = 1'b0;
        endcase
        if (bad) return 'h13;
`endif
        return refEncode(cls, f3, f7b5, rd, rs1, rs2, imm);
    endfunction

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelCount = 0;
    endtask

    // Drives one request and completes its write with wr_ready high; reports what was seen.
    task automatic sendWord(input int unsigned cls, input int unsigned f3, input int unsigned f7b5,
                            input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                            input int unsigned imm,
                            output logic [ADDR_W-1:0] gotAddr, output logic [31:0] gotData,
                            output logic gotWrEn, output bit timedOut);
        int waitCycles;
        timedOut = 1'b0;
        gotAddr = '0;
        gotData = '0;
        gotWrEn = 1'b0;
        @(negedge clk);
        req_class = cls[3:0];
        req_funct3 = f3[2:0];
        req_f7b5 = f7b5[0];
        req_rd = rd[4:0];
        req_rs1 = rs1[4:0];
        req_rs2 = rs2[4:0];
        req_imm = imm;
        req_valid = 1'b1;
        #1;
        waitCycles = 0;
        while (req_ready !== 1'b1 && waitCycles < 20) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        if (req_ready !== 1'b1) begin
            timedOut = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        gotWrEn = wr_en;
        gotAddr = wr_addr;
        gotData = wr_data;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
        $display("TXN reset: outputs checked during and after reset");
    endtask

    task automatic test_known_vectors();
        int unsigned vCls[8]  = '{0, 0, 1, 3, 7, 4, 5, 15};
        int unsigned vF3[8]   = '{0, 0, 0, 2, 0, 0, 0, 3};
        int unsigned vF7[8]   = '{0, 1, 0, 0, 0, 0, 0, 1};
        int unsigned vRd[8]   = '{3, 3, 1, 0, 5, 0, 1, 7};
        int unsigned vRs1[8]  = '{1, 1, 0, 1, 0, 0, 0, 3};
        int unsigned vRs2[8]  = '{2, 2, 0, 2, 0, 0, 0, 4};
        int unsigned vImm[8]  = '{0, 0, 32'hFFFF_FFFF, 8, 32'h1234_5000, 32'hFFFF_FFFC, 8, 99};
        logic [31:0] vWord[8] = '{32'h002081B3, 32'h402081B3, 32'hFFF00093, 32'h0020A423,
                                  32'h123452B7, 32'hFE000EE3, 32'h008000EF, 32'h00000013};
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        pulseStart();
        for (int i = 0; i < 8; i++) begin
            if (modelCount == DEPTH) pulseStart();
            sendWord(vCls[i], vF3[i], vF7[i], vRd[i], vRs1[i], vRs2[i], vImm[i],
                     gotAddr, gotData, gotWrEn, timedOut);
            checks++; if (timedOut) begin failures++; $display("FAIL vec%0d_accept: got no req_ready expected req_ready 1", i); end
            checks++; if (gotWrEn !== 1'b1) begin failures++; $display("FAIL vec%0d_wr_en: got %b expected 1", i, gotWrEn); end
            checks++; if (gotAddr !== ADDR_W'(modelCount)) begin failures++; $display("FAIL vec%0d_addr: got %0d expected %0d", i, gotAddr, modelCount); end
            checks++; if (gotData !== vWord[i]) begin failures++; $display("FAIL vec%0d_data: got %h expected %h", i, gotData, vWord[i]); end
            checks++; if (refEncode(vCls[i], vF3[i], vF7[i], vRd[i], vRs1[i], vRs2[i], vImm[i]) !== vWord[i]) begin
                failures++; $display("FAIL vec%0d_model: got %h expected %h", i,
                    refEncode(vCls[i], vF3[i], vF7[i], vRd[i], vRs1[i], vRs2[i], vImm[i]), vWord[i]);
            end
            modelCount++;
            checks++; if (count !== (ADDR_W + 1)'(modelCount)) begin failures++; $display("FAIL vec%0d_count: got %0d expected %0d", i, count, modelCount); end
            $display("TXN vector %0d class=%0d addr=%0d data=%h", i, vCls[i], gotAddr, gotData);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        int unsigned cls, f3, f7, rd, rs1, rs2, imm, expWord;
        pulseStart();
        for (int i = 0; i < 20; i++) begin
            if (modelCount == DEPTH) pulseStart();
            cls = $urandom_range(0, 15);
            f3 = $urandom_range(0, 7);
            f7 = $urandom_range(0, 1);
            rd = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 4095) - 2048);
            expWord = refExpected(cls, f3, f7, rd, rs1, rs2, imm);
            sendWord(cls, f3, f7, rd, rs1, rs2, imm, gotAddr, gotData, gotWrEn, timedOut);
            checks++; if (timedOut || gotWrEn !== 1'b1) begin failures++; $display("FAIL rand%0d_handshake: got wr_en %b timeout %0d expected wr_en 1 timeout 0", i, gotWrEn, timedOut); end
            checks++; if (gotAddr !== ADDR_W'(modelCount)) begin failures++; $display("FAIL rand%0d_addr: got %0d expected %0d", i, gotAddr, modelCount); end
            checks++; if (gotData !== expWord) begin failures++; $display("FAIL rand%0d_data: got %h expected %h", i, gotData, expWord); end
            modelCount++;
            checks++; if (count !== (ADDR_W + 1)'(modelCount)) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", i, count, modelCount); end
            $display("TXN random %0d class=%0d imm=%h addr=%0d data=%h", i, cls, imm, gotAddr, gotData);
        end
    endtask

    task automatic test_stall();
        logic [ADDR_W-1:0] addr0;
        logic [31:0] data0;
        pulseStart();
        @(negedge clk);
        req_class = 4'd1; req_funct3 = 3'd0; req_f7b5 = 1'b0;
        req_rd = 5'd1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_idle: got %b expected 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        addr0 = wr_addr;
        data0 = wr_data;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL stall_wr_en_rise: got %b expected 1", wr_en); end
        checks++; if (data0 !== refExpected(1, 0, 0, 1, 0, 0, 5)) begin failures++; $display("FAIL stall_data: got %h expected %h", data0, refExpected(1, 0, 0, 1, 0, 0, 5)); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (wr_en !== 1'b1 || wr_addr !== addr0 || wr_data !== data0) begin
                failures++; $display("FAIL stall_hold%0d: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", k, wr_en, wr_addr, wr_data, addr0, data0);
            end
            checks++; if (req_ready !== 1'b0 || count !== '0) begin
                failures++; $display("FAIL stall_block%0d: got ready=%b count=%0d expected ready=0 count=0", k, req_ready, count);
            end
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        modelCount = 1;
        checks++; if (count !== (ADDR_W + 1)'(1) || wr_en !== 1'b0) begin failures++; $display("FAIL stall_release: got count=%0d en=%b expected count=1 en=0", count, wr_en); end
        $display("TXN stall: addr=%0d data=%h held 3 cycles", addr0, data0);
    endtask

    task automatic test_full();
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        pulseStart();
        for (int i = 0; i < DEPTH; i++) begin
            sendWord(0, 0, 0, i + 1, 2, 3, 0, gotAddr, gotData, gotWrEn, timedOut);
            modelCount++;
        end
        checks++; if (full !== 1'b1 || count !== (ADDR_W + 1)'(DEPTH)) begin failures++; $display("FAIL full_flag: got full=%b count=%0d expected full=1 count=%0d", full, count, DEPTH); end
        @(negedge clk);
        req_class = 4'd0; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (req_ready !== 1'b0 || wr_en !== 1'b0 || count !== (ADDR_W + 1)'(DEPTH)) begin
                failures++; $display("FAIL full_stall%0d: got ready=%b en=%b count=%0d expected ready=0 en=0 count=%0d", k, req_ready, wr_en, count, DEPTH);
            end
        end
        start = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL start_vs_valid_ready: got %b expected 0", req_ready); end
        @(negedge clk);
        start = 1'b0;
        req_valid = 1'b0;
        modelCount = 0;
        checks++; if (count !== '0 || full !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("FAIL full_start_clear: got count=%0d full=%b en=%b expected 0 0 0", count, full, wr_en);
        end
        sendWord(7, 0, 0, 9, 0, 0, 32'hABCDE000, gotAddr, gotData, gotWrEn, timedOut);
        modelCount++;
        checks++; if (timedOut || gotAddr !== '0 || gotData !== refExpected(7, 0, 0, 9, 0, 0, 32'hABCDE000)) begin
            failures++; $display("FAIL full_restart_word: got addr=%0d data=%h expected addr=0 data=%h", gotAddr, gotData, refExpected(7, 0, 0, 9, 0, 0, 32'hABCDE000));
        end
        $display("TXN full: stalled at count %0d, restarted at addr %0d", DEPTH, gotAddr);
    endtask

    task automatic test_start_abort();
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        pulseStart();
        sendWord(0, 0, 0, 3, 1, 2, 0, gotAddr, gotData, gotWrEn, timedOut);
        modelCount++;
        @(negedge clk);
        req_class = 4'd2; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(1)) begin failures++; $display("FAIL abort_pending: got en=%b addr=%0d expected en=1 addr=1", wr_en, wr_addr); end
        start = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b expected 0", req_ready); end
        @(negedge clk);
        start = 1'b0;
        modelCount = 0;
        checks++; if (wr_en !== 1'b0 || count !== '0) begin failures++; $display("FAIL abort_drop: got en=%b count=%0d expected en=0 count=0", wr_en, count); end
        sendWord(6, 5, 0, 4, 6, 0, 32'd12, gotAddr, gotData, gotWrEn, timedOut);
        modelCount++;
        checks++; if (gotAddr !== '0 || gotData !== refExpected(6, 5, 0, 4, 6, 0, 12)) begin
            failures++; $display("FAIL abort_next_word: got addr=%0d data=%h expected addr=0 data=%h", gotAddr, gotData, refExpected(6, 5, 0, 4, 6, 0, 12));
        end
        $display("TXN start_abort: pending word dropped, next word at addr %0d data=%h", gotAddr, gotData);
    endtask

    task automatic test_async_reset();
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        pulseStart();
        @(negedge clk);
        req_class = 4'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL areset_pre: got %b expected 1", wr_en); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || count !== '0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL areset_drop: got en=%b count=%0d ready=%b expected 0 0 0", wr_en, count, req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        modelCount = 0;
        sendWord(8, 0, 0, 2, 0, 0, 32'h00001000, gotAddr, gotData, gotWrEn, timedOut);
        modelCount++;
        checks++; if (gotAddr !== '0 || gotData !== 32'h00001117) begin failures++; $display("FAIL areset_after: got addr=%0d data=%h expected addr=0 data=00001117", gotAddr, gotData); end
        $display("TXN async_reset: word lost, restart addr=%0d data=%h", gotAddr, gotData);
    endtask

    task automatic test_err();
        logic [ADDR_W-1:0] gotAddr;
        logic [31:0] gotData;
        logic gotWrEn;
        bit timedOut;
        pulseStart();
        sendWord(4, 0, 0, 0, 0, 0, 32'd3, gotAddr, gotData, gotWrEn, timedOut);
        modelCount++;
`ifdef ENC_RANGE_CHECK_EN
        checks++; if (gotData !== 32'h00000013) begin failures++; $display("FAIL err_word: got %h expected 00000013", gotData); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag: got %b expected 1", err); end
`else
        checks++; if (gotData !== 32'h00000163) begin failures++; $display("FAIL err_word: got %h expected 00000163", gotData); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_flag: got %b expected 0", err); end
`endif
        checks++; if (count !== (ADDR_W + 1)'(1)) begin failures++; $display("FAIL err_count: got %0d expected 1", count); end
        pulseStart();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err); end
        $display("TXN err: beq imm 3 data=%h", gotData);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_stall();
        test_full();
        test_start_abort();
        test_async_reset();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
